uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- CLKS_PER_BIT, 434: clocks per bit period; legal range 8..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- uart_rxd, input, 1: serial line, asynchronous to clk, idle high.
- data_valid, output, 1: one-cycle pulse, frame complete.
- data, output, DATA_BITS: received word, LSB first on the line.
- parity_err, output, 1: parity mismatch for the current frame; valid when data_valid = 1.
- frame_err, output, 1: a stop bit was sampled low; valid when data_valid = 1.
- busy, output, 1: high in any state other than IDLE.

Function
REQ-003 uart_rxd SHALL pass through a 2-flop synchroniser; all logic SHALL use only the synchronised value (rxd_s).
REQ-004 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-005 IDLE -> START SHALL occur on a falling edge of rxd_s (previous 1, current 0), with the bit counter cleared.
REQ-006 In every non-IDLE state the bit counter (width $clog2(CLKS_PER_BIT)) SHALL count 0..CLKS_PER_BIT-1, then wrap to 0 and advance to the next bit.
REQ-007 Each bit SHALL be sampled by a 2-of-3 majority vote of rxd_s at counts M-1, M and M+1, where M = CLKS_PER_BIT/2 (integer division).
REQ-008 Start-bit check: if the vote at the end of count M+1 in START is 1, the block SHALL treat it as a false start and return to IDLE without pulsing data_valid.
REQ-009 Otherwise the block SHALL enter DATA at counter wrap. DATA SHALL shift bits LSB first, exactly DATA_BITS bits, tracked by a bit index of width $clog2(DATA_BITS+1).
REQ-010 After the last data bit: if PARITY != 0 the next state SHALL be PARITY, else STOP.
REQ-011 Parity rules:
- odd: parity_err = 1 when XOR(data bits, parity bit) = 0.
- even: parity_err = 1 when XOR(data bits, parity bit) = 1.
- PARITY = 0: parity_err SHALL be constant 0.
REQ-012 STOP SHALL sample STOP_BITS stop bits. frame_err SHALL be set if any stop-bit vote is 0.
REQ-013 On the cycle after the vote of the final stop bit completes (count M+1), the block SHALL do all of the following:
- update data, parity_err and frame_err;
- pulse data_valid high for exactly 1 clk;
- return to IDLE without waiting for the rest of the stop bit.
REQ-014 data, parity_err and frame_err SHALL hold their values until the next data_valid pulse.
REQ-015 Frames with errors SHALL still produce data_valid, with the relevant error flag high.
REQ-016 After frame_err, re-arm SHALL require rxd_s to return high; a line held low (break) SHALL produce no further frames.
REQ-017 A falling edge on rxd_s while busy = 1 SHALL NOT restart the frame.
REQ-018 Latency: data_valid SHALL rise 2 (synchroniser) + 1 (edge detect) + (N-1)*CLKS_PER_BIT + M + 3 clocks after the uart_rxd start edge, where N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS. A bench tolerance of +/-1 clock is permitted.

Reset
REQ-019 While rst_n = 0, the block SHALL hold these values:
- state = IDLE; counters = 0;
- synchroniser flops and edge-detect register = 1;
- data_valid = 0, data = 0, parity_err = 0, frame_err = 0, busy = 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no data_valid.
REQ-021 After rst_n deasserts, the block SHALL accept a frame only on a subsequent falling edge; a line already low at deassertion SHALL NOT start a frame.

Verification
All scenarios use CLKS_PER_BIT = 16 unless stated.
REQ-022 Defaults (8N1): send 0xA5 -> one data_valid pulse, data = 0xA5, parity_err = 0, frame_err = 0, pulse at the REQ-018 latency; busy low afterwards.
REQ-023 DATA_BITS = 7, PARITY = 2 (even), STOP_BITS = 2:
- send 0x55 with parity bit 0 -> data = 0x55, parity_err = 0.
- resend with parity bit 1 -> parity_err = 1, data = 0x55.
REQ-024 Glitches:
- 4-clk low glitch on idle line -> false start, no data_valid, back to IDLE.
- 1-clk high spike at a data-bit centre of 0x00 -> data = 0x00 (majority vote).
REQ-025 Send 0x3C with stop bit 0, then hold the line low for 40 bit times -> one data_valid with frame_err = 1, data = 0x3C; no further pulses until the line goes high, then 0x81 is received correctly.
REQ-026 Assert rst_n = 0 during bit 4 of 0xFF -> no data_valid; all outputs at reset values. Release reset and send 0x12 -> data = 0x12.
REQ-027 Back-to-back: send 0x01, 0x80, 0xFF with no idle gap -> three data_valid pulses, in order, each with correct data and no error flags.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, start-edge detection,
// 2-of-3 majority sampling per bit, optional parity and one or two stop bits.
// A received word is presented with a single-cycle data_valid strobe together
// with its parity and framing status, which hold until the next strobe.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int M     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SMP0_CNT = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] SMP1_CNT = CNT_W'(M);
    localparam logic [CNT_W-1:0] SMP2_CNT = CNT_W'(M + 1);
    // The three samples are registered, so the vote is usable one count later.
    localparam logic [CNT_W-1:0] VOTE_CNT = CNT_W'(M + 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state, state_next;

    logic                 rxd_meta, rxd_s, rxd_prev;
    logic [1:0]           settle;
    logic                 armed;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [2:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;

    logic fall, cnt_wrap, at_vote, vote, last_data, last_stop, finish;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_check(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = ^{d, p};
        case (PARITY)
            1:       return ~x;
            2:       return x;
            default: return 1'b0;
        endcase
    endfunction

    assign fall      = armed & rxd_prev & ~rxd_s;
    assign cnt_wrap  = (cnt == CNT_LAST);
    assign at_vote   = (cnt == VOTE_CNT);
    assign vote      = maj3(smp[0], smp[1], smp[2]);
    assign last_data = (bit_idx == IDX_LAST);
    assign last_stop = (stop_idx == STOP_LAST);
    assign busy      = (state != ST_IDLE);

    // Synchronise the line and arm edge detection only once the synchronised
    // line has been seen high after reset, so a line low at release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
            settle   <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
            settle   <= {settle[0], 1'b1};
            if (settle[1] && rxd_s) armed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next-state decode; finish marks the final stop-bit vote.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) state_next = ST_START;
            end
            ST_START: begin
                if (at_vote && vote) state_next = ST_IDLE;
                else if (cnt_wrap)   state_next = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_wrap && last_data)
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (cnt_wrap) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (at_vote && last_stop) begin
                    state_next = ST_IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bit-period counter plus data-bit and stop-bit indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (state == ST_IDLE || state_next == ST_IDLE) cnt <= '0;
            else if (cnt_wrap)                             cnt <= '0;
            else                                           cnt <= cnt + 1'b1;

            if (state != ST_DATA) bit_idx <= '0;
            else if (cnt_wrap)    bit_idx <= bit_idx + 1'b1;

            if (state != ST_STOP) stop_idx <= 1'b0;
            else if (cnt_wrap)    stop_idx <= stop_idx + 1'b1;
        end
    end

    // Mid-bit samples, data shift register (LSB first) and parity bit capture.
    always_ff @(posedge clk) begin
        if (cnt == SMP0_CNT) smp[0] <= rxd_s;
        if (cnt == SMP1_CNT) smp[1] <= rxd_s;
        if (cnt == SMP2_CNT) smp[2] <= rxd_s;
        if (state == ST_DATA && at_vote)   shreg   <= {vote, shreg[DATA_BITS-1:1]};
        if (state == ST_PARITY && at_vote) par_bit <= vote;
    end

    // Framing accumulation and the registered result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_acc   <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state == ST_START)                        ferr_acc <= 1'b0;
            else if (state == ST_STOP && at_vote && !vote) ferr_acc <= 1'b1;

            data_valid <= finish;
            if (finish) begin
                data       <= shreg;
                parity_err <= parity_check(shreg, par_bit);
                frame_err  <= ferr_acc | ~vote;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, both at 16
// clocks per bit. Frames are driven bit-accurately; expected words are queued
// when a frame starts and checked, with latency, when data_valid fires.
module tb_uart_rx_cfg;

    localparam int C = 16;
    localparam int M = C / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd8, rxd7;
    logic       dv8, pe8, fe8, busy8;
    logic [7:0] data8;
    logic       dv7, pe7, fe7, busy7;
    logic [6:0] data7;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         t0;
        int         lat;
    } exp_t;

    typedef struct {
        int         which;
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] xd;
        logic       xp;
        logic       xf;
    } vec_t;

    exp_t q8[$];
    exp_t q7[$];
    exp_t e8, e7;
    logic prev8 = 1'b0;
    logic prev7 = 1'b0;
    vec_t tbl[10];

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd8), .data_valid(dv8),
        .data(data8), .parity_err(pe8), .frame_err(fe8), .busy(busy8)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd7), .data_valid(dv7),
        .data(data7), .parity_err(pe7), .frame_err(fe7), .busy(busy7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_lat(input string name, input int got, input int want);
        n_checks++;
        if (got < want - 1 || got > want + 1) begin
            n_fail++;
            $display("FAIL %s: latency %0d expected %0d +/-1", name, got, want);
        end
    endtask

    // Scoreboard for the 8N1 instance.
    always @(negedge clk) begin
        if (prev8) chk("dv8_width", 32'(dv8), 32'd0);
        if (dv8) begin
            if (q8.size() == 0) chk("dv8_unexpected", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("dv8_data", 32'(data8), 32'(e8.data[7:0]));
                chk("dv8_perr", 32'(pe8), 32'(e8.perr));
                chk("dv8_ferr", 32'(fe8), 32'(e8.ferr));
                chk_lat("dv8_lat", cyc - e8.t0, e8.lat);
            end
        end
        prev8 <= dv8;
    end

    // Scoreboard for the 7E2 instance.
    always @(negedge clk) begin
        if (prev7) chk("dv7_width", 32'(dv7), 32'd0);
        if (dv7) begin
            if (q7.size() == 0) chk("dv7_unexpected", 32'd1, 32'd0);
            else begin
                e7 = q7.pop_front();
                chk("dv7_data", 32'(data7), 32'(e7.data[6:0]));
                chk("dv7_perr", 32'(pe7), 32'(e7.perr));
                chk("dv7_ferr", 32'(fe7), 32'(e7.ferr));
                chk_lat("dv7_lat", cyc - e7.t0, e7.lat);
            end
        end
        prev7 <= dv7;
    end

    task automatic set_line(input int which, input logic v);
        if (which == 7) rxd7 = v;
        else            rxd8 = v;
    endtask

    task automatic hold(input int which, input logic v, input int n);
        set_line(which, v);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; spike_bit >= 0 flips the line for one clock mid data bit.
    task automatic send(input int which, input logic [8:0] d, input logic pbit,
                        input logic [1:0] stops, input int spike_bit,
                        input logic [8:0] xd, input logic xp, input logic xf);
        exp_t e;
        int nbits, nstop, nfr;
        nbits = (which == 7) ? 7 : 8;
        nstop = (which == 7) ? 2 : 1;
        nfr   = 1 + nbits + ((which == 7) ? 1 : 0) + nstop;
        e.data = xd;
        e.perr = xp;
        e.ferr = xf;
        e.t0   = cyc;
        e.lat  = 3 + (nfr - 1) * C + M + 3;
        if (which == 7) q7.push_back(e);
        else            q8.push_back(e);
        hold(which, 1'b0, C);
        for (int i = 0; i < nbits; i++)
            for (int c = 0; c < C; c++) begin
                set_line(which, d[i] ^ ((i == spike_bit) && (c == M)));
                @(negedge clk);
            end
        if (which == 7) hold(which, pbit, C);
        for (int s = 0; s < nstop; s++) hold(which, stops[s], C);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_busy;

        tbl[0] = '{8, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        tbl[1] = '{8, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        tbl[2] = '{8, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        tbl[3] = '{7, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
        tbl[4] = '{7, 9'h055, 1'b1, 2'b11, 9'h055, 1'b1, 1'b0};
        tbl[5] = '{7, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b0, 1'b0};
        tbl[6] = '{7, 9'h001, 1'b0, 2'b11, 9'h001, 1'b1, 1'b0};
        tbl[7] = '{7, 9'h02A, 1'b1, 2'b01, 9'h02A, 1'b0, 1'b1};
        tbl[8] = '{7, 9'h033, 1'b0, 2'b10, 9'h033, 1'b0, 1'b1};
        tbl[9] = '{8, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};

        rst_n = 1'b0;
        rxd8  = 1'b1;
        rxd7  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_dv8", 32'(dv8), 32'd0);
        chk("rst_data8", 32'(data8), 32'd0);
        chk("rst_pe8", 32'(pe8), 32'd0);
        chk("rst_fe8", 32'(fe8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_dv7", 32'(dv7), 32'd0);
        chk("rst_data7", 32'(data7), 32'd0);
        chk("rst_busy7", 32'(busy7), 32'd0);
        rst_n = 1'b1;
        repeat (2 * C) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            send(tbl[v].which, tbl[v].d, tbl[v].pbit, tbl[v].stops, -1,
                 tbl[v].xd, tbl[v].xp, tbl[v].xf);
            hold(tbl[v].which, 1'b1, 3 * C);
            chk("idle_busy", 32'((tbl[v].which == 7) ? busy7 : busy8), 32'd0);
        end

        // Short low glitch: START is entered, then rejected with no strobe.
        hold(8, 1'b0, 4);
        chk("glitch_busy_hi", 32'(busy8), 32'd1);
        hold(8, 1'b1, 2 * C);
        chk("glitch_busy_lo", 32'(busy8), 32'd0);

        // One-clock high spike at the centre of data bit 3 of 0x00.
        send(8, 9'h000, 1'b0, 2'b11, 3, 9'h000, 1'b0, 1'b0);
        hold(8, 1'b1, 2 * C);

        // Framing error followed by a long break, then a good frame.
        send(8, 9'h03C, 1'b0, 2'b00, -1, 9'h03C, 1'b0, 1'b1);
        hold(8, 1'b0, 40 * C);
        chk("break_busy", 32'(busy8), 32'd0);
        hold(8, 1'b1, 2 * C);
        send(8, 9'h081, 1'b0, 2'b11, -1, 9'h081, 1'b0, 1'b0);
        hold(8, 1'b1, 2 * C);

        // Back-to-back frames without idle time.
        send(8, 9'h001, 1'b0, 2'b11, -1, 9'h001, 1'b0, 1'b0);
        send(8, 9'h080, 1'b0, 2'b11, -1, 9'h080, 1'b0, 1'b0);
        send(8, 9'h0FF, 1'b0, 2'b11, -1, 9'h0FF, 1'b0, 1'b0);
        hold(8, 1'b1, 3 * C);

        // Reset during bit 4 of 0xFF, released while the line is low.
        hold(8, 1'b0, C);
        hold(8, 1'b1, 4 * C + M);
        chk("midrst_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        rxd8  = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_dv8", 32'(dv8), 32'd0);
        chk("midrst_data8", 32'(data8), 32'd0);
        chk("midrst_pe8", 32'(pe8), 32'd0);
        chk("midrst_fe8", 32'(fe8), 32'd0);
        chk("midrst_busy8", 32'(busy8), 32'd0);
        chk("midrst_data7", 32'(data7), 32'd0);
        chk("midrst_fe7", 32'(fe7), 32'd0);
        chk("midrst_pe7", 32'(pe7), 32'd0);
        rst_n = 1'b1;
        saw_busy = 1'b0;
        repeat (3 * C) begin
            @(negedge clk);
            if (busy8) saw_busy = 1'b1;
        end
        chk("low_at_release_no_start", 32'(saw_busy), 32'd0);
        hold(8, 1'b1, 2 * C);
        send(8, 9'h012, 1'b0, 2'b11, -1, 9'h012, 1'b0, 1'b0);
        hold(8, 1'b1, 3 * C);

        for (int i = 0; i < 500 && (q8.size() != 0 || q7.size() != 0); i++)
            @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q7_drained", 32'(q7.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
